// File: rtl/write_back_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : write_back_stage_pkg
// Description : Shared types and constants for the write-back stage:
//               register index/value/file types, architectural slot
//               indices (Flags, PC), reset register file and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package write_back_stage_pkg;

  localparam int          NR     = 4;              // register count
  localparam logic [31:0] PC_INC = 32'd4;          // PC advance on retire
  localparam logic [31:0] NOP    = 32'h8000_0000;  // squashed-slot marker
  localparam int          FLAGS  = NR - 1;         // Flags slot
  localparam int          PC     = NR - 2;         // PC slot

  typedef logic [4:0]        regind_t;
  typedef logic [31:0]       regval_t;
  typedef regval_t [NR-1:0]  regfile_t;

  localparam regfile_t ZERO_REGFILE = '0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STORE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/write_back_stage_regfile_writer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writer
// Description : Combinational next-state of the register file for one
//               retiring instruction.
//   i_regs        current register file
//   i_reg_write   1 = register retire, 0 = PC advance only (store)
//   i_dst         destination index (entries >= NR are ignored)
//   i_value       value for i_dst
//   i_upper       value for i_dst+1 when i_has_upper
//   i_flags       new flags
//   i_pc          pc of the retiring instruction
//   o_regs        next register file
//   o_redirect    destination is the PC slot
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writer
  import write_back_stage_pkg::*;
(
  input  regfile_t   i_regs,
  input  logic       i_reg_write,
  input  regind_t    i_dst,
  input  regval_t    i_value,
  input  regval_t    i_upper,
  input  logic       i_has_upper,
  input  logic [3:0] i_flags,
  input  regval_t    i_pc,
  output regfile_t   o_regs,
  output logic       o_redirect
);

  // One extra bit so that index 31 + 1 does not wrap onto slot 0.
  logic [5:0] w_dst_ext;
  logic [5:0] w_upper_idx;

  assign w_dst_ext   = {1'b0, i_dst};
  assign w_upper_idx = w_dst_ext + 6'd1;
  assign o_redirect  = i_reg_write && (w_dst_ext == 6'(PC));

  // Defaults first (flags, pc increment), then the explicit register
  // writes, so a register write to Flags/PC always takes precedence.
  always_comb begin
    o_regs     = i_regs;
    o_regs[PC] = i_pc + PC_INC;
    if (i_reg_write) begin
      o_regs[FLAGS] = {28'd0, i_flags};
      for (int i = 1; i < NR; i++) begin
        if (w_dst_ext == 6'(i)) begin
          o_regs[i] = i_value;
        end
        if (i_has_upper && (w_upper_idx == 6'(i))) begin
          o_regs[i] = i_upper;
        end
      end
    end
    o_regs[0] = '0;
  end

endmodule
`default_nettype wire

// File: rtl/write_back_stage.sv
`default_nettype none
// ============================================================================
// Module      : write_back_stage
// Description : Final pipeline stage. Retires one instruction per accepted
//               transfer: register file / Flags / PC update, single-beat
//               store, registered feedback and one-cycle redirect pulse.
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ex_*                  execute->write bundle, ex_hold stalls execute
//   registers             architectural register file
//   fb_*                  feedback (forwarding) path
//   next_pc, has_flushed  redirect to fetch
//   mem_*                 store bus (beat done on mem_write && !mem_waitrequest)
// Revision    : 1.0 - initial release
// ============================================================================
module write_back_stage
  import write_back_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_is_valid,
  output logic        ex_hold,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_adjustment_value,
  input  logic [31:0] ex_destination_value,
  input  logic [31:0] ex_upper_value,
  input  regind_t     ex_destination_register,
  input  logic [3:0]  ex_flags,
  input  logic        ex_has_flushed,
  input  logic        ex_is_writing_memory,
  input  logic        ex_has_upper_value,
  output regfile_t    registers,
  output logic [31:0] fb_value,
  output logic [31:0] fb_upper_value,
  output regind_t     fb_index,
  output logic        fb_is_valid,
  output logic        fb_has_upper_value,
  output logic [31:0] next_pc,
  output logic        has_flushed,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  input  logic        mem_waitrequest
);

  state_t   r_state;
  state_t   w_state_next;
  regfile_t r_regs;
  regfile_t w_regs_next;
  logic     w_redirect;
  logic     w_accept;
  logic     w_retire;
  logic     w_store;
  logic     w_reg_retire;
  logic     w_store_done;

  // ex_hold is low only in IDLE, so every accept happens in IDLE.
  assign w_accept     = ex_is_valid && !ex_hold;
  assign w_retire     = w_accept && !ex_has_flushed;
  assign w_store      = w_retire && ex_is_writing_memory;
  assign w_reg_retire = w_retire && !ex_is_writing_memory;
  assign w_store_done = (r_state == ST_STORE) && !mem_waitrequest;

  regfile_writer u_regfile_writer (
    .i_regs      (r_regs),
    .i_reg_write (w_reg_retire),
    .i_dst       (ex_destination_register),
    .i_value     (ex_destination_value),
    .i_upper     (ex_upper_value),
    .i_has_upper (ex_has_upper_value),
    .i_flags     (ex_flags),
    .i_pc        (ex_pc),
    .o_regs      (w_regs_next),
    .o_redirect  (w_redirect)
  );

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_store)      w_state_next = ST_STORE;
      ST_STORE: if (w_store_done) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ex_hold = (r_state == ST_STORE);
  end

  // Architectural registers, feedback, redirect and store bus
  always_ff @(posedge clock) begin
    if (reset) begin
      r_regs             <= ZERO_REGFILE;
      fb_value           <= '0;
      fb_upper_value     <= '0;
      fb_index           <= '0;
      fb_is_valid        <= 1'b0;
      fb_has_upper_value <= 1'b0;
      next_pc            <= '0;
      has_flushed        <= 1'b0;
      mem_write          <= 1'b0;
      mem_address        <= '0;
      mem_write_data     <= '0;
    end else begin
      fb_is_valid <= 1'b0;
      has_flushed <= 1'b0;
      if (w_retire) begin
        r_regs <= w_regs_next;
      end
      if (w_reg_retire) begin
        fb_is_valid        <= 1'b1;
        fb_index           <= ex_destination_register;
        fb_value           <= ex_destination_value;
        fb_upper_value     <= ex_upper_value;
        fb_has_upper_value <= ex_has_upper_value;
        if (w_redirect) begin
          next_pc     <= ex_destination_value;
          has_flushed <= 1'b1;
        end
      end
      if (w_store) begin
        mem_write      <= 1'b1;
        mem_address    <= ex_adjustment_value;
        mem_write_data <= ex_destination_value;
      end else if (w_store_done) begin
        mem_write <= 1'b0;
      end
    end
  end

  assign registers = r_regs;

endmodule
`default_nettype wire

// File: tb/tb_write_back_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_back_stage
// Description : Self-checking bench for write_back_stage: directed
//               scenarios followed by randomized traffic, all compared
//               against a behavioural model of the retire rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_back_stage;
  import write_back_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_is_valid;
  logic        ex_hold;
  logic [31:0] ex_pc;
  logic [31:0] ex_adjustment_value;
  logic [31:0] ex_destination_value;
  logic [31:0] ex_upper_value;
  regind_t     ex_destination_register;
  logic [3:0]  ex_flags;
  logic        ex_has_flushed;
  logic        ex_is_writing_memory;
  logic        ex_has_upper_value;
  regfile_t    registers;
  logic [31:0] fb_value;
  logic [31:0] fb_upper_value;
  regind_t     fb_index;
  logic        fb_is_valid;
  logic        fb_has_upper_value;
  logic [31:0] next_pc;
  logic        has_flushed;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_waitrequest;

  always #5 clock = ~clock;

  write_back_stage dut (
    .clock                   (clock),
    .reset                   (reset),
    .ex_is_valid             (ex_is_valid),
    .ex_hold                 (ex_hold),
    .ex_pc                   (ex_pc),
    .ex_adjustment_value     (ex_adjustment_value),
    .ex_destination_value    (ex_destination_value),
    .ex_upper_value          (ex_upper_value),
    .ex_destination_register (ex_destination_register),
    .ex_flags                (ex_flags),
    .ex_has_flushed          (ex_has_flushed),
    .ex_is_writing_memory    (ex_is_writing_memory),
    .ex_has_upper_value      (ex_has_upper_value),
    .registers               (registers),
    .fb_value                (fb_value),
    .fb_upper_value          (fb_upper_value),
    .fb_index                (fb_index),
    .fb_is_valid             (fb_is_valid),
    .fb_has_upper_value      (fb_has_upper_value),
    .next_pc                 (next_pc),
    .has_flushed             (has_flushed),
    .mem_address             (mem_address),
    .mem_write_data          (mem_write_data),
    .mem_write               (mem_write),
    .mem_waitrequest         (mem_waitrequest)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: slot 1 general, slot 2 = PC, slot 3 = Flags.
  logic [31:0] m_regs [0:3];
  bit          m_busy;
  logic [31:0] m_addr, m_data, m_npc;
  bit          m_flush, m_fbv, m_fbhu;
  int          m_fbi;
  logic [31:0] m_fbval, m_fbup;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_busy = 0; m_addr = '0; m_data = '0; m_npc = '0;
    m_flush = 0; m_fbv = 0; m_fbhu = 0; m_fbi = 0; m_fbval = '0; m_fbup = '0;
  endtask

  task automatic model_update();
    int d;
    logic [31:0] v, u;
    bit hu;
    logic [31:0] n1, n2, n3;
    if (reset) begin
      model_reset();
      return;
    end
    m_fbv = 0;
    m_flush = 0;
    if (m_busy) begin
      if (!mem_waitrequest) m_busy = 0;
    end else if (ex_is_valid && !ex_has_flushed) begin
      if (ex_is_writing_memory) begin
        m_busy = 1;
        m_addr = ex_adjustment_value;
        m_data = ex_destination_value;
        m_regs[2] = ex_pc + 32'd4;
      end else begin
        d  = int'(ex_destination_register);
        v  = ex_destination_value;
        u  = ex_upper_value;
        hu = ex_has_upper_value;
        n1 = (d == 1) ? v : (hu && d == 0) ? u : m_regs[1];
        n2 = (d == 2) ? v : (hu && d == 1) ? u : ex_pc + 32'd4;
        n3 = (d == 3) ? v : (hu && d == 2) ? u : {28'd0, ex_flags};
        m_regs[1] = n1; m_regs[2] = n2; m_regs[3] = n3;
        if (d == 2) begin
          m_flush = 1;
          m_npc = v;
        end
        m_fbv = 1; m_fbi = d; m_fbval = v; m_fbup = u; m_fbhu = hu;
      end
    end
  endtask

  task automatic check_all();
    check("ex_hold", {31'd0, ex_hold}, {31'd0, m_busy});
    for (int i = 0; i < 4; i++) check($sformatf("reg%0d", i), registers[i], m_regs[i]);
    check("mem_write", {31'd0, mem_write}, {31'd0, m_busy});
    if (m_busy) begin
      check("mem_address", mem_address, m_addr);
      check("mem_write_data", mem_write_data, m_data);
    end
    check("next_pc", next_pc, m_npc);
    check("has_flushed", {31'd0, has_flushed}, {31'd0, m_flush});
    check("fb_is_valid", {31'd0, fb_is_valid}, {31'd0, m_fbv});
    if (m_fbv) begin
      check("fb_index", {27'd0, fb_index}, 32'(m_fbi));
      check("fb_value", fb_value, m_fbval);
      check("fb_has_upper", {31'd0, fb_has_upper_value}, {31'd0, m_fbhu});
      if (m_fbhu) check("fb_upper_value", fb_upper_value, m_fbup);
    end
  endtask

  // Inputs are changed at the falling edge; the model advances with the
  // rising edge and the DUT is compared at the next falling edge.
  task automatic tick();
    model_update();
    @(negedge clock);
    check_all();
  endtask

  task automatic drive(input bit valid, input bit sq, input bit st, input int d,
                       input logic [31:0] v, input logic [31:0] u, input bit hu,
                       input logic [3:0] fl, input logic [31:0] pc, input logic [31:0] adj);
    ex_is_valid = valid; ex_has_flushed = sq; ex_is_writing_memory = st;
    ex_destination_register = regind_t'(d); ex_destination_value = v;
    ex_upper_value = u; ex_has_upper_value = hu; ex_flags = fl;
    ex_pc = pc; ex_adjustment_value = adj;
  endtask

  task automatic idle();
    ex_is_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst fb_value", fb_value, 32'd0);
    check("rst fb_upper", fb_upper_value, 32'd0);
    check("rst fb_index", {27'd0, fb_index}, 32'd0);
    check("rst fb_has_upper", {31'd0, fb_has_upper_value}, 32'd0);
    check("rst mem_address", mem_address, 32'd0);
    check("rst mem_write_data", mem_write_data, 32'd0);
  endtask

  initial begin
    int wcount;
    model_reset();
    reset = 1'b1;
    mem_waitrequest = 1'b0;
    drive(0, 0, 0, 0, '0, '0, 0, 4'h0, '0, '0);
    @(negedge clock);
    tick();
    tick();
    check_reset_outputs();
    reset = 1'b0;

    // Basic register retire
    drive(1, 0, 0, 1, 32'h1234, 32'h0, 0, 4'h5, 32'h100, 32'h0);
    tick();
    check("t1 r1", registers[1], 32'h1234);
    check("t1 pc", registers[PC], 32'h104);
    check("t1 flags", registers[FLAGS], 32'h5);

    // Upper into PC slot wins over increment; no redirect
    drive(1, 0, 0, 1, 32'hA, 32'hB, 1, 4'h2, 32'h200, 32'h0);
    tick();
    check("t2 pc slot", registers[PC], 32'hB);
    // Destination is Flags, upper dropped
    drive(1, 0, 0, 3, 32'h77, 32'h88, 1, 4'h9, 32'h300, 32'h0);
    tick();
    check("t3 flags slot", registers[FLAGS], 32'h77);

    // Redirect: one-cycle flush pulse
    drive(1, 0, 0, 2, 32'h2000, 32'h0, 0, 4'h1, 32'h400, 32'h0);
    tick();
    check("t4 next_pc", next_pc, 32'h2000);
    idle();
    tick();
    tick();

    // Store with three wait cycles; a pending transfer must wait
    drive(1, 0, 1, 0, 32'hDEAD, 32'h0, 0, 4'h0, 32'h500, 32'h40);
    tick();
    wcount = 0;
    drive(1, 0, 0, 1, 32'h5555, 32'h0, 0, 4'h6, 32'h600, 32'h0);
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (mem_write) wcount++;
      tick();
    end
    mem_waitrequest = 1'b0;
    if (mem_write) wcount++;
    tick();
    check("store beat cycles", 32'(wcount), 32'd4);
    tick();
    check("t5 late accept r1", registers[1], 32'h5555);
    idle();
    tick();

    // Squashed transfer has no effect
    drive(1, 1, 0, 1, 32'h999, 32'h0, 0, 4'hF, 32'h700, 32'h0);
    tick();
    idle();
    tick();

    // Reset in the middle of a store
    drive(1, 0, 1, 0, 32'hBEEF, 32'h0, 0, 4'h0, 32'h800, 32'h80);
    tick();
    idle();
    mem_waitrequest = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_reset_outputs();
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      reset = ($urandom_range(0, 99) == 0);
      mem_waitrequest = $urandom_range(0, 1) == 1;
      drive($urandom_range(0, 9) < 7,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 6) == 0,
            (sel < 6) ? sel : 31,
            $urandom, $urandom,
            $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)),
            $urandom, $urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
